// File: rtl/program_loader.sv
// program_loader: UART (8N1) boot loader. Receives a length-prefixed,
// little-endian program image, assembles 32-bit words and writes them into
// program memory, then raises load_done to release the processor.
module program_loader #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     serial_rx,
  output logic                     write_enabled,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [31:0]              write_value,
  output logic                     load_done,
  output logic                     load_error
);

  // Bit timing: the start bit is re-sampled half a bit after the falling
  // edge, every later sample lands one full bit period further on.
  localparam logic [15:0] FULL_M1   = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1   = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDRESS_WIDTH);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    LD_COUNT_LO,
    LD_COUNT_HI,
    LD_PAYLOAD,
    LD_DONE,
    LD_ERROR
  } ld_state_e;

  // Reset synchronizer outputs
  logic                   rst_meta_q;
  logic                   rst_sync_n_q;

  // Line synchronizer and edge history
  logic                   rx_meta_q;
  logic                   rx_sync_q;
  logic                   rx_prev_q;

  // Receiver state
  rx_state_e              rx_state_q;
  logic [15:0]            clk_cnt_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic                   byte_valid_q;
  logic                   frame_err_q;

  // Loader state
  ld_state_e              ld_state_q;
  logic [15:0]            count_q;
  logic [ADDRESS_WIDTH:0] word_cnt_q;
  logic [1:0]             byte_idx_q;
  logic [23:0]            asm_q;

  // Word count as it will be once the high header byte is latched.
  logic [15:0]            count_full;
  // True when the word just strobed is the last one of the image.
  logic                   last_word;

  assign count_full = {shift_q, count_q[7:0]};
  assign last_word  = ((17'(word_cnt_q) + 17'd1) == {1'b0, count_q});

  // Reset asserts asynchronously everywhere but is released on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q   <= 1'b0;
      rst_sync_n_q <= 1'b0;
    end else begin
      rst_meta_q   <= 1'b1;
      rst_sync_n_q <= rst_meta_q;
    end
  end

  // Two-flop synchronizer on the asynchronous line plus one flop of history
  // for falling-edge detection; all reset to the idle (high) level.
  always_ff @(posedge clk or negedge rst_sync_n_q) begin
    if (!rst_sync_n_q) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= serial_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // UART receive FSM: start-bit qualification, 8 LSB-first data bits, stop
  // check; emits a one-cycle byte_valid or frame_err pulse per frame.
  always_ff @(posedge clk or negedge rst_sync_n_q) begin
    if (!rst_sync_n_q) begin
      rx_state_q   <= RX_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      unique case (rx_state_q)
        RX_IDLE: begin
          clk_cnt_q <= '0;
          bit_cnt_q <= '0;
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (clk_cnt_q == HALF_M1) begin
            clk_cnt_q <= '0;
            // A line that is high again at mid start bit was only a glitch.
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
        RX_DATA: begin
          if (clk_cnt_q == FULL_M1) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
        RX_STOP: begin
          if (clk_cnt_q == FULL_M1) begin
            clk_cnt_q  <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_sync_q) begin
              byte_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Loader FSM: parses the 16-bit word count, packs payload bytes into words,
  // strobes each finished word into memory and tracks completion/errors.
  // shift_q is stable during the byte_valid cycle, so it is the byte itself.
  always_ff @(posedge clk or negedge rst_sync_n_q) begin
    if (!rst_sync_n_q) begin
      ld_state_q    <= LD_COUNT_LO;
      count_q       <= '0;
      word_cnt_q    <= '0;
      byte_idx_q    <= '0;
      asm_q         <= '0;
      write_enabled <= 1'b0;
      write_address <= '0;
      write_value   <= '0;
      load_done     <= 1'b0;
      load_error    <= 1'b0;
    end else begin
      write_enabled <= 1'b0;
      if (frame_err_q && (ld_state_q != LD_DONE)) begin
        // Once the image is complete, line noise can no longer spoil it.
        ld_state_q <= LD_ERROR;
        load_error <= 1'b1;
      end else begin
        unique case (ld_state_q)
          LD_COUNT_LO: begin
            if (byte_valid_q) begin
              count_q[7:0] <= shift_q;
              ld_state_q   <= LD_COUNT_HI;
            end
          end
          LD_COUNT_HI: begin
            if (byte_valid_q) begin
              count_q[15:8] <= shift_q;
              if (count_full == 16'd0) begin
                ld_state_q <= LD_DONE;
                load_done  <= 1'b1;
              end else if ({1'b0, count_full} > MAX_WORDS) begin
                ld_state_q <= LD_ERROR;
                load_error <= 1'b1;
              end else begin
                ld_state_q <= LD_PAYLOAD;
              end
            end
          end
          LD_PAYLOAD: begin
            if (write_enabled) begin
              // Count the word in the cycle after its strobe; completion is
              // therefore visible one cycle after the final write.
              word_cnt_q <= word_cnt_q + 1'b1;
              if (last_word) begin
                ld_state_q <= LD_DONE;
                load_done  <= 1'b1;
              end
            end else if (byte_valid_q) begin
              byte_idx_q <= byte_idx_q + 2'd1;
              if (byte_idx_q == 2'd3) begin
                write_enabled <= 1'b1;
                write_address <= word_cnt_q[ADDRESS_WIDTH-1:0];
                write_value   <= {shift_q, asm_q};
              end else begin
                asm_q[8*byte_idx_q +: 8] <= shift_q;
              end
            end
          end
          LD_DONE: begin
            ld_state_q <= LD_DONE;
          end
          LD_ERROR: begin
            ld_state_q <= LD_ERROR;
          end
          default: ld_state_q <= LD_ERROR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: byte-level reference model of the image
// format plus a per-cycle compare process on the memory write port.
`timescale 1ns/1ps
module tb_program_loader;

  localparam int CPB  = 4;
  localparam int AW   = 2;
  localparam int MAXW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          serial_rx = 1'b1;
  logic          write_enabled;
  logic [AW-1:0] write_address;
  logic [31:0]   write_value;
  logic          load_done;
  logic          load_error;

  program_loader #(
    .CLKS_PER_BIT (CPB),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .serial_rx    (serial_rx),
    .write_enabled(write_enabled),
    .write_address(write_address),
    .write_value  (write_value),
    .load_done    (load_done),
    .load_error   (load_error)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          addr;
    logic [31:0] val;
  } wr_t;

  wr_t         exp_q[$];

  // Reference model state (byte-stream level)
  int          m_pos  = 0;
  int          m_n    = 0;
  bit          m_done = 1'b0;
  bit          m_err  = 1'b0;
  logic [31:0] m_word = '0;

  // Observations gathered by the compare process
  int          cyc = 0;
  int          n_strobes = 0;
  int          done_rise_cyc = -1;
  int          last_strobe_cyc = -1;
  int          last_stop_cyc = -1;
  logic [31:0] log_val[$];
  int          log_addr[$];
  logic        prev_we = 1'b0;
  logic        prev_done = 1'b0;
  logic        prev_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pos  = 0;
    m_n    = 0;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_word = '0;
  endfunction

  // Apply one received frame to the model: header bytes set N, payload byte
  // p goes to word p/4 at byte lane p%4.
  function automatic void model_byte(input logic [7:0] b, input bit ok);
    int  k;
    int  w;
    wr_t e;
    if (m_done || m_err) return;
    if (!ok) begin
      m_err = 1'b1;
      return;
    end
    if (m_pos == 0) begin
      m_n = int'(b);
    end else if (m_pos == 1) begin
      m_n = m_n + 256 * int'(b);
      if (m_n == 0) m_done = 1'b1;
      else if (m_n > MAXW) m_err = 1'b1;
    end else begin
      k = (m_pos - 2) % 4;
      w = (m_pos - 2) / 4;
      m_word[8*k +: 8] = b;
      if (k == 3) begin
        e.addr = w;
        e.val  = m_word;
        exp_q.push_back(e);
        if (w + 1 == m_n) m_done = 1'b1;
      end
    end
    m_pos++;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit ok);
    model_byte(b, ok);
    @(negedge clk) serial_rx = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) serial_rx = b[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk) serial_rx = ok;
    last_stop_cyc = cyc;
    repeat (CPB - 1) @(negedge clk);
    @(negedge clk) serial_rx = 1'b1;
    repeat (8) @(negedge clk);
    chk("done_after_byte", 64'(load_done), 64'(m_done));
    chk("error_after_byte", 64'(load_error), 64'(m_err));
  endtask

  task automatic glitch();
    @(negedge clk) serial_rx = 1'b0;
    @(negedge clk) serial_rx = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_no_error", 64'(load_error), 64'(m_err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    serial_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_we", 64'(write_enabled), 64'(0));
    chk("reset_addr", 64'(write_address), 64'(0));
    chk("reset_value", 64'(write_value), 64'(0));
    chk("reset_done", 64'(load_done), 64'(0));
    chk("reset_error", 64'(load_error), 64'(0));
    model_reset();
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Per-cycle compare on the write port and the status levels.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_we       = 1'b0;
        prev_done     = 1'b0;
        prev_err      = 1'b0;
        n_strobes     = 0;
        done_rise_cyc = -1;
        log_val.delete();
        log_addr.delete();
      end else begin
        if (write_enabled) begin
          chk("strobe_single_cycle", 64'(prev_we), 64'(0));
          n_strobes++;
          last_strobe_cyc = cyc;
          log_val.push_back(write_value);
          log_addr.push_back(int'(write_address));
          chk("strobe_expected", 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("write_address", 64'(write_address), 64'(e.addr));
            chk("write_value", 64'(write_value), 64'(e.val));
          end
        end
        if (load_done && !prev_done) done_rise_cyc = cyc;
        if (prev_done) chk("done_sticky", 64'(load_done), 64'(1));
        if (prev_err) chk("error_sticky", 64'(load_error), 64'(1));
        if (load_done || load_error) chk("done_and_error_exclusive", 64'(load_done & load_error), 64'(0));
        prev_we   = write_enabled;
        prev_done = load_done;
        prev_err  = load_error;
      end
    end
  end

  logic [7:0] img1 [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

  initial begin
    int          r;
    int          nb;
    int          bad_at;
    logic [15:0] hdr;
    logic [7:0]  b;

    // 1: two-word image
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(img1[i], 1'b1);
    chk("t1_strobes", 64'(n_strobes), 64'(2));
    if (log_val.size() == 2) begin
      chk("t1_addr0", 64'(log_addr[0]), 64'(0));
      chk("t1_val0", 64'(log_val[0]), 64'(32'h00100513));
      chk("t1_addr1", 64'(log_addr[1]), 64'(1));
      chk("t1_val1", 64'(log_val[1]), 64'(32'h00200593));
    end
    chk("t1_done_latency", 64'(done_rise_cyc - last_strobe_cyc), 64'(1));
    chk("t1_done", 64'(load_done), 64'(1));
    chk("t1_error", 64'(load_error), 64'(0));

    // 2: empty image
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("t2_done", 64'(load_done), 64'(1));
    chk("t2_done_soon", 64'((done_rise_cyc > last_stop_cyc) && (done_rise_cyc - last_stop_cyc <= CPB + 4)), 64'(1));
    chk("t2_strobes", 64'(n_strobes), 64'(0));

    // 3: oversize count, then exactly full memory
    do_reset();
    send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("t3_error", 64'(load_error), 64'(1));
    chk("t3_done", 64'(load_done), 64'(0));
    chk("t3_strobes", 64'(n_strobes), 64'(0));
    do_reset();
    send_byte(8'h04, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b1);
    chk("t3_full_strobes", 64'(n_strobes), 64'(4));
    for (int i = 0; i < 4; i++) begin
      if (log_addr.size() > i) chk("t3_full_addr", 64'(log_addr[i]), 64'(i));
    end
    chk("t3_full_done", 64'(load_done), 64'(1));

    // 4: framing error on the 3rd byte
    do_reset();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h5a, 1'b0);
    chk("t4_error", 64'(load_error), 64'(1));
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
    chk("t4_strobes", 64'(n_strobes), 64'(0));
    chk("t4_error_held", 64'(load_error), 64'(1));
    chk("t4_done", 64'(load_done), 64'(0));

    // 5: glitch, reset mid-word, resend
    do_reset();
    glitch();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'haa, 1'b1);
    send_byte(8'hbb, 1'b1);
    do_reset();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    glitch();
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("t5_strobes", 64'(n_strobes), 64'(1));
    if (log_val.size() == 1) begin
      chk("t5_addr", 64'(log_addr[0]), 64'(0));
      chk("t5_val", 64'(log_val[0]), 64'(32'h00100513));
    end
    chk("t5_done", 64'(load_done), 64'(1));

    // 6: traffic after completion is ignored
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1);
    chk("t6_strobes", 64'(n_strobes), 64'(1));
    chk("t6_done", 64'(load_done), 64'(1));

    // Randomized sessions against the model
    for (int s = 0; s < 15; s++) begin
      do_reset();
      r = int'($urandom_range(0, 9));
      if (r == 0) hdr = 16'($urandom_range(MAXW + 1, 65535));
      else        hdr = 16'($urandom_range(0, MAXW));
      nb     = 2 + ((r == 0) ? 0 : int'(hdr) * 4) + int'($urandom_range(0, 3));
      bad_at = (r <= 2) ? int'($urandom_range(0, nb - 1)) : -1;
      for (int i = 0; i < nb; i++) begin
        if (i == 0)      b = hdr[7:0];
        else if (i == 1) b = hdr[15:8];
        else             b = 8'($urandom);
        send_byte(b, i != bad_at);
      end
      chk("rand_pending_writes", 64'(exp_q.size()), 64'(0));
    end

    chk("final_pending_writes", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
